// File: rtl/reg_bank_sync.sv
// Clocked register bank: one write port, two registered read ports, with an
// optional hardwired-zero entry 0, write-to-read bypass and a post-reset clear sequencer.
module reg_bank_sync #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                ZERO_REG = 0,
    parameter int                BYPASS   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] wa,
    input  logic              rw,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              re,
    output logic [DATA_W-1:0] dr1,
    output logic [DATA_W-1:0] dr2,
    output logic              ready,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] dr1_q, dr1_d;
    logic [DATA_W-1:0] dr2_q, dr2_d;
    logic              ready_q, ready_d;
    logic              wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0] br_q [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // Zero rule outranks the bypass, which outranks the stored value.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [ADDR_W-1:0] w_addr,
        input logic              w_en,
        input logic [DATA_W-1:0] w_data,
        input logic [DATA_W-1:0] stored
    );
        if ((ZERO_REG != 0) && (ra == '0)) begin
            return '0;
        end else if ((BYPASS != 0) && w_en && (w_addr == ra)) begin
            return w_data;
        end else begin
            return stored;
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dr1_d     = dr1_q;
        dr2_d     = dr2_q;
        ready_d   = ready_q;
        wr_drop_d = 1'b0;
        we        = 1'b0;
        waddr     = wa;
        wdata     = din;

        case (state_q)
            CLEAR: begin
                we        = 1'b1;
                waddr     = cnt_q[ADDR_W-1:0];
                wdata     = INIT_VAL;
                cnt_d     = cnt_q + 1'b1;
                dr1_d     = '0;
                dr2_d     = '0;
                ready_d   = 1'b0;
                wr_drop_d = rw;
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                we      = rw && !((ZERO_REG != 0) && (wa == '0));
                ready_d = 1'b1;
                if (re) begin
                    dr1_d = read_port(ra1, wa, rw, din, br_q[ra1]);
                    dr2_d = read_port(ra2, wa, rw, din, br_q[ra2]);
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase

        // The reset edge itself leaves the array untouched.
        if (!rst_n) begin
            we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            dr1_q     <= '0;
            dr2_q     <= '0;
            ready_q   <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dr1_q     <= dr1_d;
            dr2_q     <= dr2_d;
            ready_q   <= ready_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            br_q[waddr] <= wdata;
        end
    end

    assign dr1     = dr1_q;
    assign dr2     = dr2_q;
    assign ready   = ready_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_reg_bank_sync.sv
// Bench for reg_bank_sync: three configurations driven in parallel and checked
// against an array-based model every cycle, plus hand-computed spot checks.
module tb_reg_bank_sync;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din = '0;
    logic [4:0]  wa = '0;
    logic        rw = 1'b0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic        re = 1'b0;

    logic [31:0] dr1_0, dr2_0, dr1_1, dr2_1, dr1_2, dr2_2;
    logic        ready_0, ready_1, ready_2;
    logic        wr_drop_0, wr_drop_1, wr_drop_2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // u0: defaults (bypass on); u1: no bypass, nonzero init; u2: hardwired zero.
    reg_bank_sync u0 (
        .clk(clk), .rst_n(rst_n), .din(din), .wa(wa), .rw(rw), .ra1(ra1), .ra2(ra2),
        .re(re), .dr1(dr1_0), .dr2(dr2_0), .ready(ready_0), .wr_drop(wr_drop_0)
    );
    reg_bank_sync #(.BYPASS(0), .INIT_VAL(32'h0000_00A5)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din), .wa(wa), .rw(rw), .ra1(ra1), .ra2(ra2),
        .re(re), .dr1(dr1_1), .dr2(dr2_1), .ready(ready_1), .wr_drop(wr_drop_1)
    );
    reg_bank_sync #(.ZERO_REG(1)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din), .wa(wa), .rw(rw), .ra1(ra1), .ra2(ra2),
        .re(re), .dr1(dr1_2), .dr2(dr2_2), .ready(ready_2), .wr_drop(wr_drop_2)
    );

    // ---------------- behavioural model ----------------
    int          cfg_zero [3] = '{0, 0, 1};
    int          cfg_byp  [3] = '{1, 0, 1};
    logic [31:0] cfg_init [3] = '{32'h0, 32'hA5, 32'h0};

    logic [31:0] m_mem [3][32];
    logic [31:0] m_dr1 [3];
    logic [31:0] m_dr2 [3];
    logic        m_ready = 1'b0;
    logic        m_drop  = 1'b0;
    int          m_clr   = 0;
    bit          m_run   = 1'b0;
    bit          chk_en  = 1'b0;

    function automatic logic [31:0] model_read(input int c, input logic [4:0] a);
        if (cfg_zero[c] != 0 && a == 5'd0) return 32'h0;
        if (cfg_byp[c] != 0 && rw && wa == a) return din;
        return m_mem[c][a];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_clr   = 0;
            m_run   = 1'b0;
            m_ready = 1'b0;
            m_drop  = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_dr1[c] = '0;
                m_dr2[c] = '0;
            end
            chk_en = 1'b1;
        end else if (!m_run) begin
            m_drop = rw;
            for (int c = 0; c < 3; c++) begin
                m_mem[c][m_clr] = cfg_init[c];
                m_dr1[c] = '0;
                m_dr2[c] = '0;
            end
            m_clr++;
            if (m_clr == 32) begin
                m_run   = 1'b1;
                m_ready = 1'b1;
            end
        end else begin
            m_drop = 1'b0;
            for (int c = 0; c < 3; c++) begin
                if (re) begin
                    m_dr1[c] = model_read(c, ra1);
                    m_dr2[c] = model_read(c, ra2);
                end
            end
            for (int c = 0; c < 3; c++) begin
                if (rw && !(cfg_zero[c] != 0 && wa == 5'd0)) m_mem[c][wa] = din;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("u0.dr1", dr1_0, m_dr1[0]);
            check("u0.dr2", dr2_0, m_dr2[0]);
            check("u1.dr1", dr1_1, m_dr1[1]);
            check("u1.dr2", dr2_1, m_dr2[1]);
            check("u2.dr1", dr1_2, m_dr1[2]);
            check("u2.dr2", dr2_2, m_dr2[2]);
            check("u0.ready", {31'b0, ready_0}, {31'b0, m_ready});
            check("u1.ready", {31'b0, ready_1}, {31'b0, m_ready});
            check("u2.ready", {31'b0, ready_2}, {31'b0, m_ready});
            check("u0.wr_drop", {31'b0, wr_drop_0}, {31'b0, m_drop});
            check("u1.wr_drop", {31'b0, wr_drop_1}, {31'b0, m_drop});
            check("u2.wr_drop", {31'b0, wr_drop_2}, {31'b0, m_drop});
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input bit r, input bit w, input logic [4:0] a_w, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2, input bit e);
        rst_n = r;
        rw    = w;
        wa    = a_w;
        din   = d;
        ra1   = a1;
        ra2   = a2;
        re    = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        // Clear sequence after a two-cycle reset.
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        check("rst.ready", {31'b0, ready_0}, 32'd0);
        check("rst.dr1", dr1_0, 32'd0);
        for (int i = 1; i <= 32; i++) begin
            idle();
            if (i == 31) check("clr.ready_at_31", {31'b0, ready_0}, 32'd0);
            if (i == 32) check("clr.ready_at_32", {31'b0, ready_0}, 32'd1);
        end
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b1);
        end

        // Basic write then read.
        cyc(1'b1, 1'b1, 5'd3, 32'd77, 5'd0, 5'd0, 1'b0);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd5, 1'b1);
        check("basic.dr1", dr1_0, 32'd77);
        check("basic.dr2", dr2_0, 32'd0);
        check("basic.u1_init", dr2_1, 32'hA5);

        // Bypass versus read-before-write.
        cyc(1'b1, 1'b1, 5'd9, 32'd14, 5'd0, 5'd0, 1'b0);
        cyc(1'b1, 1'b1, 5'd9, 32'd720, 5'd9, 5'd0, 1'b1);
        check("byp.on", dr1_0, 32'd720);
        check("byp.off_old", dr1_1, 32'd14);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b1);
        check("byp.off_new", dr1_1, 32'd720);

        // Zero register.
        cyc(1'b1, 1'b1, 5'd0, 32'd49, 5'd0, 5'd0, 1'b0);
        check("zero.no_drop", {31'b0, wr_drop_2}, 32'd0);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        check("zero.dr1", dr1_2, 32'd0);
        check("zero.dr2", dr2_2, 32'd0);
        check("nozero.dr1", dr1_0, 32'd49);
        check("nozero.dr2", dr2_0, 32'd49);

        // Mixed traffic, some cycles hitting the bypass and the zero entry.
        for (int i = 0; i < 24; i++) begin
            logic [4:0] a_w;
            a_w = 5'((i * 7 + 2) % 32);
            cyc(1'b1, (i % 3) != 2, a_w, $urandom_range(0, 32'hFFFF),
                (i % 4 == 0) ? a_w : 5'((i * 5) % 32), 5'(i % 32), (i % 5) != 4);
        end

        // Hold with re=0, writes still land.
        cyc(1'b1, 1'b1, 5'd24, 32'd20000, 5'd0, 5'd0, 1'b0);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd24, 5'd24, 1'b1);
        check("hold.read", dr1_0, 32'd20000);
        cyc(1'b1, 1'b1, 5'd11, 32'd33, 5'd3, 5'd11, 1'b0);
        check("hold.dr1", dr1_0, 32'd20000);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd11, 5'd11, 1'b1);
        check("hold.write_landed", dr1_0, 32'd33);

        // Reset mid-run, write during clear, reset again mid-clear.
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        check("rerst.dr1", dr1_0, 32'd0);
        check("rerst.dr2", dr2_0, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            if (i == 4) begin
                cyc(1'b1, 1'b1, 5'd7, 32'd7, 5'd7, 5'd0, 1'b1);
                check("clrwr.drop_hi", {31'b0, wr_drop_0}, 32'd1);
                check("clrwr.dr1_held", dr1_0, 32'd0);
            end else begin
                idle();
                if (i == 5) check("clrwr.drop_lo", {31'b0, wr_drop_0}, 32'd0);
            end
        end
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            idle();
            if (i == 31) check("clr2.ready_at_31", {31'b0, ready_0}, 32'd0);
            if (i == 32) check("clr2.ready_at_32", {31'b0, ready_0}, 32'd1);
        end
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd24, 5'd7, 1'b1);
        check("clr2.br24", dr1_0, 32'd0);
        check("clr2.br7", dr2_0, 32'd0);
        check("clr2.u1_br24", dr1_1, 32'hA5);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
